ring_freq_counter: RTL

//  Measures the ring-divider output frequency against the system clock: counts rising edges of
//  the asynchronous divided ring signal over a fixed gate of clk cycles and reports the count

---
 rtl/ring_freq_counter_pkg.sv | 19 +
 rtl/ring_freq_counter_if.sv | 14 +
 rtl/ring_freq_counter_edge_sync.sv | 25 ++
 rtl/ring_freq_counter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/ring_freq_counter_pkg.sv
// Shared types and defaults for the ring-divider frequency counter.
package ring_freq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_GATE_CYCLES = 1024;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    // Width of the down-counter that spans one gate window (holds GATE_CYCLES-1).
    function automatic int gate_cnt_w(input int gate_cycles);
        return $clog2(gate_cycles);
    endfunction

endpackage

// File: rtl/ring_freq_counter_if.sv
// Measurement request / result handshake between consumer (master) and counter (slave).
interface ring_freq_counter_if #(
    parameter int CNT_W = ring_freq_pkg::DEF_CNT_W
);
    logic             start;
    logic             ack;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (output start, ack, input busy, valid, count, overflow);
    modport slave  (input start, ack, output busy, valid, count, overflow);
endinterface

// File: rtl/ring_freq_counter_edge_sync.sv
// Brings the asynchronous ring signal into the clk domain and flags its rising edges.
module ring_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic edge_det
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    // Synchronizer shift chain followed by one delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/ring_freq_counter.sv
// Counts rising edges of the divided ring signal over a GATE_CYCLES clk window and
// hands the result over a valid/ack handshake.
// Optional feature macro: RING_FREQ_CONTINUOUS_EN (back-to-back windows while start is held).
module ring_freq_counter
    import ring_freq_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ring_in,
    ring_freq_counter_if.slave  bus
);
    localparam int             GW        = gate_cnt_w(GATE_CYCLES);
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_n;
    logic [GW-1:0]     gate_cnt, gate_cnt_n;
    logic [CNT_W-1:0]  edge_cnt, edge_cnt_n, acc_cnt;
    logic              ovf, ovf_n, acc_ovf;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              overflow_q, overflow_n;
    logic              valid_q, valid_n;
    logic              edge_det;

    ring_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .d_async  (ring_in),
        .edge_det (edge_det)
    );

    // State and datapath registers; reset discards any in-flight measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_n;
            gate_cnt   <= gate_cnt_n;
            edge_cnt   <= edge_cnt_n;
            ovf        <= ovf_n;
            count_q    <= count_n;
            overflow_q <= overflow_n;
            valid_q    <= valid_n;
        end
    end

    // Next-state logic; acc_* is the running window total including this cycle's edge.
    always_comb begin
        acc_cnt    = edge_cnt;
        acc_ovf    = ovf;
        state_n    = state;
        gate_cnt_n = gate_cnt;
        edge_cnt_n = edge_cnt;
        ovf_n      = ovf;
        count_n    = count_q;
        overflow_n = overflow_q;
        valid_n    = valid_q;

        if (edge_det) begin
            if (edge_cnt == CNT_MAX) acc_ovf = 1'b1;
            else                     acc_cnt = edge_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n    = GATE;
                    gate_cnt_n = GATE_LAST;
                    edge_cnt_n = '0;
                    ovf_n      = 1'b0;
                end
            end
            GATE: begin
                valid_n    = 1'b0;
                edge_cnt_n = acc_cnt;
                ovf_n      = acc_ovf;
                gate_cnt_n = gate_cnt - 1'b1;
                if (gate_cnt == '0) begin
                    count_n    = acc_cnt;
                    overflow_n = acc_ovf;
                    valid_n    = 1'b1;
`ifdef RING_FREQ_CONTINUOUS_EN
                    // The final-cycle edge belongs to the closing window, so the next
                    // window starts from zero: nothing is counted twice or dropped.
                    if (bus.start) begin
                        gate_cnt_n = GATE_LAST;
                        edge_cnt_n = '0;
                        ovf_n      = 1'b0;
                    end else begin
                        state_n = HOLD;
                    end
`else
                    state_n = HOLD;
`endif
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.valid    = valid_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule
